// File: rtl/adder_error_monitor_if.sv
// Sample/statistics port bundle for the adder error monitor.
// The master side is the upstream adder stage and the characterisation consumer;
// the slave side is the monitor itself.
interface adder_error_monitor_if #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
);
  logic             start;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] exact_sum;
  logic [WIDTH-1:0] approx_sum;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] err_count;
  logic [WIDTH-1:0] max_ed;
  logic [ACC_W-1:0] sum_ed;
  logic             sat;

  modport master (
    output start, abort, in_valid, exact_sum, approx_sum, out_ready,
    input  in_ready, busy, out_valid, err_count, max_ed, sum_ed, sat
  );

  modport slave (
    input  start, abort, in_valid, exact_sum, approx_sum, out_ready,
    output in_ready, busy, out_valid, err_count, max_ed, sum_ed, sat
  );
endinterface

// File: rtl/adder_error_monitor.sv
// Error-distance monitor for an approximate adder: over a window of WINDOW
// samples it counts mismatches, tracks the largest error distance and sums
// the error distances (saturating), then offers the result on a valid/ready port.
// Two-stage datapath: stage 1 registers |exact-approx|, stage 2 accumulates.
module adder_error_monitor #(
  parameter int WIDTH  = 5,
  parameter int WINDOW = 256,
  parameter int CNT_W  = 16,
  parameter int ACC_W  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_error_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WIN_C    = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_clear;
  logic             w_flush;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_ed;
  logic             r_neq;
  logic             r_pipe_valid;

  logic [CNT_W-1:0] r_err_count;
  logic [WIDTH-1:0] r_max_ed;
  logic [ACC_W-1:0] r_sum_ed;
  logic             r_sat;

  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_ed;
  logic [ACC_W:0]   w_sum_ext;

  // One extra bit keeps the sign of the difference so the distance never wraps.
  assign w_diff    = {1'b0, bus.exact_sum} - {1'b0, bus.approx_sum};
  assign w_ed      = w_diff[WIDTH] ? (bus.approx_sum - bus.exact_sum) : w_diff[WIDTH-1:0];
  // The carry out of this add is exactly the "true sum exceeded the range" flag.
  assign w_sum_ext = {1'b0, r_sum_ed} + (ACC_W+1)'(r_ed);

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.out_valid = (r_state == S_REPORT);
  assign bus.err_count = r_err_count;
  assign bus.max_ed    = r_max_ed;
  assign bus.sum_ed    = r_sum_ed;
  assign bus.sat       = r_sat;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decode; abort beats a simultaneous sample.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_clear      = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_RUN;
          w_clear      = 1'b1;
        end
      end
      S_RUN: begin
        w_in_ready = (r_cnt < WIN_C);
        if (bus.abort) begin
          w_state_next = S_IDLE;
          w_flush      = 1'b1;
        end else if (bus.in_valid && w_in_ready) begin
          w_accept = 1'b1;
          if (r_cnt == WIN_LAST) begin
            w_state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (bus.abort) begin
          w_state_next = S_IDLE;
          w_flush      = 1'b1;
        end else if (r_pipe_valid) begin
          w_state_next = S_REPORT;
        end
      end
      S_REPORT: begin
        if (bus.out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Stage 1: capture the per-sample distance and advance the sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_ed         <= '0;
      r_neq        <= 1'b0;
      r_pipe_valid <= 1'b0;
    end else if (w_clear) begin
      r_cnt        <= '0;
      r_pipe_valid <= 1'b0;
    end else begin
      r_pipe_valid <= w_accept;
      if (w_accept) begin
        r_ed  <= w_ed;
        r_neq <= (bus.exact_sum != bus.approx_sum);
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 2: fold the registered distance into the window statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
      r_max_ed    <= '0;
      r_sum_ed    <= '0;
      r_sat       <= 1'b0;
    end else if (w_clear) begin
      r_err_count <= '0;
      r_max_ed    <= '0;
      r_sum_ed    <= '0;
      r_sat       <= 1'b0;
    end else if (r_pipe_valid && !w_flush) begin
      if (r_neq) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
      if (r_ed > r_max_ed) begin
        r_max_ed <= r_ed;
      end
      if (w_sum_ext[ACC_W]) begin
        r_sum_ed <= '1;
        r_sat    <= 1'b1;
      end else begin
        r_sum_ed <= w_sum_ext[ACC_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_adder_error_monitor.sv
// Self-checking bench for adder_error_monitor: directed scenarios plus
// randomized windows checked against a list-based statistics model.
module tb_adder_error_monitor;

  localparam int WIDTH   = 5;
  localparam int CNT_W   = 16;
  localparam int ACC_W   = 5;
  localparam int WINDOW  = 4;
  localparam int SUM_MAX = (1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_error_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) bus ();
  adder_error_monitor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(24))    bus1 ();

  adder_error_monitor #(.WIDTH(WIDTH), .WINDOW(WINDOW), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  adder_error_monitor #(.WIDTH(WIDTH), .WINDOW(1), .CNT_W(CNT_W), .ACC_W(24)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int tests = 0;
  int fails = 0;
  int q_ex[$];
  int q_ap[$];

  // Reference statistics straight from the definition of the window results.
  function automatic void model(output int e_err, output int e_max, output int e_sum, output logic e_sat);
    int tot;
    tot   = 0;
    e_err = 0;
    e_max = 0;
    foreach (q_ex[i]) begin
      int d;
      d = (q_ex[i] > q_ap[i]) ? q_ex[i] - q_ap[i] : q_ap[i] - q_ex[i];
      if (d != 0) e_err++;
      if (d > e_max) e_max = d;
      tot += d;
    end
    e_sat = (tot > SUM_MAX);
    e_sum = e_sat ? SUM_MAX : tot;
  endfunction

  // Drives one full window from q_ex/q_ap; returns with out_valid seen (or timed out).
  task automatic run_window(input int gap_lo, input int gap_hi, output bit ready_drop,
                            output bit tmo, output int ov_delay);
    ready_drop = 0;
    tmo        = 0;
    bus.out_ready = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    foreach (q_ex[i]) begin
      bus.exact_sum  = WIDTH'(q_ex[i]);
      bus.approx_sum = WIDTH'(q_ap[i]);
      bus.in_valid   = 1'b1;
      if (bus.in_ready !== 1'b1) ready_drop = 1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (i < q_ex.size() - 1) begin
        int g;
        g = $urandom_range(gap_hi, gap_lo);
        repeat (g) begin
          if (bus.in_ready !== 1'b1) ready_drop = 1;
          @(negedge clk);
        end
      end
    end
    ov_delay = 1;
    while (bus.out_valid !== 1'b1 && ov_delay < 16) begin
      @(negedge clk);
      ov_delay++;
    end
    if (bus.out_valid !== 1'b1) tmo = 1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++; if (bus.in_ready !== 1'b0)  begin fails++; $display("FAIL reset_in_ready got %0b exp 0", bus.in_ready); end
    tests++; if (bus.busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
    tests++; if (bus.err_count !== '0)   begin fails++; $display("FAIL reset_err_count got %0d exp 0", bus.err_count); end
    tests++; if (bus.max_ed !== '0)      begin fails++; $display("FAIL reset_max_ed got %0d exp 0", bus.max_ed); end
    tests++; if (bus.sum_ed !== '0)      begin fails++; $display("FAIL reset_sum_ed got %0d exp 0", bus.sum_ed); end
    tests++; if (bus.sat !== 1'b0)       begin fails++; $display("FAIL reset_sat got %0b exp 0", bus.sat); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset busy=%0b out_valid=%0b exp 0/0", bus.busy, bus.out_valid);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    bit rd, tmo;
    int dly;
    q_ex = '{10, 17, 3, 31};
    q_ap = '{10, 1, 7, 31};
    run_window(0, 0, rd, tmo, dly);
    tests++; if (tmo)           begin fails++; $display("FAIL basic_timeout got timeout exp out_valid"); end
    tests++; if (dly != 2)      begin fails++; $display("FAIL basic_latency got %0d exp 2", dly); end
    tests++; if (rd)            begin fails++; $display("FAIL basic_in_ready got drop exp steady 1"); end
    tests++; if (bus.err_count !== 16'd2) begin fails++; $display("FAIL basic_err_count got %0d exp 2", bus.err_count); end
    tests++; if (bus.max_ed !== 5'd16)    begin fails++; $display("FAIL basic_max_ed got %0d exp 16", bus.max_ed); end
    tests++; if (bus.sum_ed !== 5'd20)    begin fails++; $display("FAIL basic_sum_ed got %0d exp 20", bus.sum_ed); end
    tests++; if (bus.sat !== 1'b0)        begin fails++; $display("FAIL basic_sat got %0b exp 0", bus.sat); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL basic_one_cycle_valid out_valid=%0b busy=%0b exp 0/0", bus.out_valid, bus.busy);
    end
    tests++; if (bus.err_count !== 16'd2 || bus.sum_ed !== 5'd20) begin
      fails++; $display("FAIL basic_retained err=%0d sum=%0d exp 2/20", bus.err_count, bus.sum_ed);
    end
    $display("[TB] basic window: err=%0d max=%0d sum=%0d sat=%0b", bus.err_count, bus.max_ed, bus.sum_ed, bus.sat);
  endtask

  task automatic test_gaps();
    bit rd, tmo;
    int dly;
    q_ex = '{5, 5, 5, 5};
    q_ap = '{5, 5, 5, 5};
    run_window(1, 1, rd, tmo, dly);
    tests++; if (tmo || rd) begin fails++; $display("FAIL gaps_handshake tmo=%0b drop=%0b exp 0/0", tmo, rd); end
    tests++; if (bus.err_count !== '0 || bus.max_ed !== '0 || bus.sum_ed !== '0) begin
      fails++; $display("FAIL gaps_stats err=%0d max=%0d sum=%0d exp 0/0/0", bus.err_count, bus.max_ed, bus.sum_ed);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    $display("[TB] gapped window: err=%0d max=%0d sum=%0d", bus.err_count, bus.max_ed, bus.sum_ed);
  endtask

  task automatic test_hold();
    bit rd, tmo;
    int dly, e_err, e_max, e_sum;
    logic e_sat;
    q_ex.delete(); q_ap.delete();
    for (int i = 0; i < WINDOW; i++) begin
      q_ex.push_back($urandom_range(31, 0));
      q_ap.push_back($urandom_range(31, 0));
    end
    model(e_err, e_max, e_sum, e_sat);
    run_window(0, 0, rd, tmo, dly);
    tests++; if (tmo) begin fails++; $display("FAIL hold_timeout got timeout exp out_valid"); end
    for (int c = 0; c < 10; c++) begin
      // start and abort while reporting must both be ignored
      bus.start = (c == 3);
      bus.abort = (c == 6);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.err_count !== CNT_W'(e_err) ||
          bus.max_ed !== WIDTH'(e_max) || bus.sum_ed !== ACC_W'(e_sum) || bus.sat !== e_sat) begin
        fails++;
        $display("FAIL hold_cycle%0d got v=%0b rdy=%0b err=%0d max=%0d sum=%0d sat=%0b exp 1/0/%0d/%0d/%0d/%0b",
                 c, bus.out_valid, bus.in_ready, bus.err_count, bus.max_ed, bus.sum_ed, bus.sat,
                 e_err, e_max, e_sum, e_sat);
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL hold_release out_valid=%0b busy=%0b exp 0/0", bus.out_valid, bus.busy);
    end
    $display("[TB] held report: err=%0d max=%0d sum=%0d sat=%0b", e_err, e_max, e_sum, e_sat);
  endtask

  task automatic test_saturation();
    bit rd, tmo;
    int dly;
    q_ex = '{31, 31, 31, 31};
    q_ap = '{0, 0, 0, 0};
    run_window(0, 0, rd, tmo, dly);
    tests++; if (tmo) begin fails++; $display("FAIL sat_timeout got timeout exp out_valid"); end
    tests++; if (bus.sum_ed !== 5'd31 || bus.sat !== 1'b1) begin
      fails++; $display("FAIL sat_sum got sum=%0d sat=%0b exp 31/1", bus.sum_ed, bus.sat);
    end
    tests++; if (bus.max_ed !== 5'd31 || bus.err_count !== 16'd4) begin
      fails++; $display("FAIL sat_max_err got max=%0d err=%0d exp 31/4", bus.max_ed, bus.err_count);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    $display("[TB] saturating window: sum=%0d sat=%0b", bus.sum_ed, bus.sat);
  endtask

  task automatic test_abort();
    bit rd, tmo;
    int dly, e_err, e_max, e_sum;
    logic e_sat;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.exact_sum  = 5'd20;
      bus.approx_sum = 5'd3;
      bus.in_valid   = 1'b1;
      bus.abort      = (i == 2);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    tests++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      fails++; $display("FAIL abort_idle busy=%0b in_ready=%0b exp 0/0", bus.busy, bus.in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL abort_no_report cycle%0d got 1 exp 0", c); end
      @(negedge clk);
    end
    q_ex = '{0, 7, 9, 2};
    q_ap = '{1, 7, 30, 2};
    model(e_err, e_max, e_sum, e_sat);
    run_window(0, 1, rd, tmo, dly);
    tests++; if (tmo) begin fails++; $display("FAIL abort_restart_timeout got timeout exp out_valid"); end
    tests++; if (bus.err_count !== CNT_W'(e_err) || bus.max_ed !== WIDTH'(e_max) ||
                 bus.sum_ed !== ACC_W'(e_sum) || bus.sat !== e_sat) begin
      fails++; $display("FAIL abort_restart got err=%0d max=%0d sum=%0d sat=%0b exp %0d/%0d/%0d/%0b",
                        bus.err_count, bus.max_ed, bus.sum_ed, bus.sat, e_err, e_max, e_sum, e_sat);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    $display("[TB] abort then restart: err=%0d max=%0d sum=%0d", bus.err_count, bus.max_ed, bus.sum_ed);
  endtask

  task automatic test_async_reset();
    bit rd, tmo;
    int dly;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) begin
      bus.exact_sum  = 5'd0;
      bus.approx_sum = 5'd1;
      bus.in_valid   = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    tests++; if (bus.busy !== 1'b1 || bus.err_count !== 16'd1) begin
      fails++; $display("FAIL mid_run busy=%0b err=%0d exp 1/1", bus.busy, bus.err_count);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.err_count !== '0 ||
                 bus.max_ed !== '0 || bus.sum_ed !== '0 || bus.sat !== 1'b0) begin
      fails++; $display("FAIL async_reset busy=%0b rdy=%0b v=%0b err=%0d max=%0d sum=%0d sat=%0b exp all 0",
                        bus.busy, bus.in_ready, bus.out_valid, bus.err_count, bus.max_ed, bus.sum_ed, bus.sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    q_ex = '{0, 0, 0, 0};
    q_ap = '{1, 1, 1, 1};
    run_window(0, 0, rd, tmo, dly);
    tests++; if (tmo) begin fails++; $display("FAIL post_reset_timeout got timeout exp out_valid"); end
    tests++; if (bus.err_count !== 16'd4 || bus.sum_ed !== 5'd4 || bus.max_ed !== 5'd1) begin
      fails++; $display("FAIL post_reset got err=%0d sum=%0d max=%0d exp 4/4/1", bus.err_count, bus.sum_ed, bus.max_ed);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    $display("[TB] async reset and recovery: err=%0d sum=%0d max=%0d", bus.err_count, bus.sum_ed, bus.max_ed);
  endtask

  task automatic test_random();
    bit rd, tmo;
    int dly, e_err, e_max, e_sum, hold;
    logic e_sat;
    for (int w = 0; w < 16; w++) begin
      q_ex.delete(); q_ap.delete();
      for (int i = 0; i < WINDOW; i++) begin
        int e;
        e = $urandom_range(31, 0);
        q_ex.push_back(e);
        q_ap.push_back(($urandom_range(1, 0) == 1) ? e : $urandom_range(31, 0));
      end
      model(e_err, e_max, e_sum, e_sat);
      run_window(0, 2, rd, tmo, dly);
      tests++;
      if (tmo || rd || dly != 2 || bus.err_count !== CNT_W'(e_err) || bus.max_ed !== WIDTH'(e_max) ||
          bus.sum_ed !== ACC_W'(e_sum) || bus.sat !== e_sat) begin
        fails++;
        $display("FAIL random_w%0d got tmo=%0b drop=%0b lat=%0d err=%0d max=%0d sum=%0d sat=%0b exp 0/0/2/%0d/%0d/%0d/%0b",
                 w, tmo, rd, dly, bus.err_count, bus.max_ed, bus.sum_ed, bus.sat, e_err, e_max, e_sum, e_sat);
      end
      hold = $urandom_range(3, 0);
      repeat (hold) @(negedge clk);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL random_w%0d_consume got 1 exp 0", w); end
      $display("[TB] random window %0d: err=%0d max=%0d sum=%0d sat=%0b", w, e_err, e_max, e_sum, e_sat);
    end
  endtask

  task automatic test_window1();
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start      = 1'b0;
    bus1.exact_sum  = 5'd9;
    bus1.approx_sum = 5'd2;
    bus1.in_valid   = 1'b1;
    tests++; if (bus1.in_ready !== 1'b1) begin fails++; $display("FAIL w1_ready got %0b exp 1", bus1.in_ready); end
    @(negedge clk);
    bus1.in_valid = 1'b0;
    tests++; if (bus1.busy !== 1'b1 || bus1.in_ready !== 1'b0 || bus1.out_valid !== 1'b0) begin
      fails++; $display("FAIL w1_drain busy=%0b rdy=%0b v=%0b exp 1/0/0", bus1.busy, bus1.in_ready, bus1.out_valid);
    end
    @(negedge clk);
    tests++; if (bus1.out_valid !== 1'b1 || bus1.err_count !== 16'd1 || bus1.max_ed !== 5'd7 ||
                 bus1.sum_ed !== 24'd7 || bus1.sat !== 1'b0) begin
      fails++; $display("FAIL w1_report v=%0b err=%0d max=%0d sum=%0d sat=%0b exp 1/1/7/7/0",
                        bus1.out_valid, bus1.err_count, bus1.max_ed, bus1.sum_ed, bus1.sat);
    end
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
    tests++; if (bus1.out_valid !== 1'b0) begin fails++; $display("FAIL w1_consume got 1 exp 0"); end
    $display("[TB] single-sample window: err=%0d max=%0d sum=%0d", bus1.err_count, bus1.max_ed, bus1.sum_ed);
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.exact_sum = '0; bus.approx_sum = '0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    bus1.exact_sum = '0; bus1.approx_sum = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_hold();
    test_saturation();
    test_abort();
    test_async_reset();
    test_random();
    test_window1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_error_monitor.md
Name: adder_error_monitor

Overview:
- Downstream consumer of the approximate 5-bit adder stage.
- Each handshake takes one sample pair: the exact sum and the approximate (carry-predicted) sum.
- Over a programmable window of samples it computes the error distance per sample and accumulates: error count, maximum error distance and summed error distance.
- After the window closes it presents the statistics on a valid/ready output port for adder characterisation.

Parameters:
- WIDTH, 5, sum width in bits; both sums are unsigned.
- WINDOW, 256, number of samples per measurement (≥1).
- CNT_W, 16, width of the sample and error counters; must satisfy 2^CNT_W > WINDOW.
- ACC_W, 24, width of the summed error-distance accumulator; saturating.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a measurement (only honoured in IDLE).
- abort  in  1  single-cycle pulse; cancels the measurement in RUN/DRAIN.
- in_valid  in  1  sample pair valid.
- in_ready  out  1  block accepts a sample.
- exact_sum  in  WIDTH  reference sum.
- approx_sum  in  WIDTH  approximate adder sum.
- busy  out  1  high in RUN or DRAIN.
- out_valid  out  1  statistics valid.
- out_ready  in  1  consumer accepts the statistics.
- err_count  out  CNT_W  number of samples with exact_sum != approx_sum.
- max_ed  out  WIDTH  maximum |exact_sum − approx_sum| in the window.
- sum_ed  out  ACC_W  sum of |exact_sum − approx_sum|, saturating at 2^ACC_W−1.
- sat  out  1  sum_ed saturated during the window.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; in_ready=0, busy=0, out_valid=0; err_count, max_ed, sum_ed, sat, internal sample counter and pipeline valid all 0. Any in-flight measurement is discarded; no report is produced.
- State IDLE:
  - in_ready=0.
  - start=1 → RUN, clearing all accumulators and the sample counter on the same edge.
  - abort is ignored.
- State RUN:
  - in_ready=1 while sample counter < WINDOW.
  - A sample is accepted on an edge where in_valid && in_ready.
  - Stage 1, accept edge: register ed=|exact−approx| (WIDTH bits, computed with WIDTH+1-bit subtraction, never wraps), register neq=(exact!=approx), set pipe_valid, increment the sample counter.
  - Stage 2, next edge when pipe_valid:
    - err_count += neq;
    - max_ed = max(max_ed, ed);
    - sum_ed += ed, saturating; sat sticky-set when the true sum exceeds 2^ACC_W−1.
  - When the counter reaches WINDOW on an accept edge → DRAIN; in_ready drops to 0 in the following cycle.
- State DRAIN: waits for the last stage-2 update, then → REPORT on that edge. The last sample accepted at edge k gives out_valid=1 after edge k+1.
- State REPORT:
  - out_valid=1; outputs held stable until out_valid && out_ready.
  - On that edge → IDLE. out_valid drops; the statistic outputs keep their values until the next start.
  - start in REPORT is ignored.
- Statistic outputs are visible at all times but are only meaningful while out_valid=1.
- abort in RUN or DRAIN → IDLE next edge:
  - abort takes priority over a simultaneous sample handshake; that sample is dropped.
  - The pipeline is flushed and no out_valid is produced.
  - Accumulators retain partial values.
- abort in REPORT is ignored; the report must be consumed.
- in_valid while in_ready=0 has no effect; the upstream holds the data.
- WINDOW=1: a single accept goes RUN→DRAIN→REPORT.
- Back-to-back samples at full rate: one per cycle, no bubbles.

Test Plan:
- WINDOW=4. Pairs (exact,approx) (10,10),(17,1),(3,7),(31,31) fed back-to-back, out_ready=1 → err_count=2, max_ed=16, sum_ed=20, sat=0. out_valid rises 2 cycles after the 4th accept and lasts 1 cycle.
- WINDOW=4, all pairs equal (e.g. 5,5), in_valid toggled every other cycle → err_count=0, max_ed=0, sum_ed=0; in_ready stays 1 throughout RUN.
- WINDOW=4, out_ready held 0 for 10 cycles after out_valid → out_valid and all statistics stable for 10 cycles; IDLE on the first out_ready=1 edge; in_ready=0 throughout.
- ACC_W=5, WINDOW=4, pairs (31,0)×4 → sum_ed=31, sat=1, max_ed=31, err_count=4.
- WINDOW=8, abort asserted together with the 3rd valid sample → IDLE next cycle, busy=0, out_valid never asserts. A new start clears the counters and a full window reports correctly.
- rst_n pulled low mid-RUN after 2 samples, asynchronously between edges → all outputs 0 immediately. After release, start with WINDOW=4 samples (0,1)×4 → err_count=4, sum_ed=4, max_ed=1.
